data_bus_fifo: RTL and testbench
================================

Name: data_bus_fifo

Overview:
- Parametrised successor to the 4-bit registered data bus.
- Carries WIDTH-bit words from a producer to a consumer through a DEPTH-entry first-in-first-out buffer.
- Uses a valid/ready handshake on both sides, so the consumer can stall without losing data.
- Sits between any two blocks on the data path and replaces the plain valid-only bus wherever backpressure is needed.

Parameters:
- WIDTH, 4: data word width in bits, >=1.
- DEPTH, 4: number of storage entries, power of two, >=2.
- CNT_W, $clog2(DEPTH+1): width of the fill-level output (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous clear; empties the buffer on the next edge.
- dataIn  input  WIDTH  producer word.
- validIn  input  1  producer word valid.
- readyOut  output  1  buffer can accept a word this cycle.
- dataOut  output  WIDTH  head-of-buffer word.
- validOut  output  1  dataOut holds a valid word.
- readyIn  input  1  consumer accepts the word this cycle.
- count  output  CNT_W  current number of stored words.
- overflowErr  output  1  sticky: validIn was high while readyOut was low.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. It is fixed as such.
- Reset values: count=0, validOut=0, readyOut=1, dataOut=0, overflowErr=0, read and write pointers=0.
- Reset mid-operation: all contents are discarded immediately, with no wait for a clock edge.
- Write: occurs when validIn && readyOut at a rising edge. dataIn goes to mem[wrPtr], and wrPtr increments modulo DEPTH.
- Read: occurs when validOut && readyIn at a rising edge. rdPtr increments modulo DEPTH.
- Output data: dataOut = mem[rdPtr] when validOut is high. dataOut = 0 when the buffer is empty; stale data is never driven.
- Status decode: readyOut = (count != DEPTH) and validOut = (count != 0). Both are decoded from registered count, with no combinational path from validIn or readyIn.
- Latency: a word written at edge k into an empty buffer is on dataOut with validOut=1 after edge k. That is 1 cycle, with no fall-through in the same cycle.
- Simultaneous read and write with 0<count<DEPTH: both happen and count is unchanged.
- When full: readyOut=0, so the write is refused even if a read happens in the same cycle. The consumer read still proceeds and count becomes DEPTH-1.
- When empty: validOut=0, so readyIn is ignored and pointers do not move.
- Pointer wrap-around: pointers wrap DEPTH-1 -> 0. Ordering must hold across the wrap.
- Flush: at the edge it clears count and pointers to 0 and sets validOut=0. It has priority over any simultaneous read or write in that cycle, and the write is dropped. overflowErr is not cleared by flush.
- overflowErr: set on any edge where validIn=1 and readyOut=0. It clears only on reset.
- Storage: the mem array is not reset; only pointers and count are.
- Count arithmetic: count is updated as count + wrEn - rdEn in CNT_W bits. It never exceeds DEPTH and never underflows. Implementation asserts this.

Decomposition:
- Shared package data_bus_pkg holds the default WIDTH and DEPTH constants, and a function for pointer width ($clog2(DEPTH)) reused by later bus blocks.
- One sub-module is natural: data_bus_mem. It is a DEPTH x WIDTH register array with one write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata), and is instantiated once.
- Pointer, count and flag logic stays in data_bus_fifo.

Test Plan:
- Reset then idle: reset=1 for 5 cycles, then low -> count=0, validOut=0, readyOut=1, dataOut=4'b0000, overflowErr=0.
- Single word: write 4'b0110 for one cycle with readyIn=0 -> next cycle validOut=1, dataOut=4'b0110, count=1. Raise readyIn for one cycle -> validOut=0, count=0.
- Fill and backpressure: write 4'b0001..4'b0100 with readyIn=0 -> count=4, readyOut=0. Hold validIn=1 with 4'b1110 -> count stays 4 and overflowErr=1. Drain with readyIn=1 -> outputs 0001,0010,0011,0100 in order, and 1110 never appears.
- Streaming with wrap: continuous validIn=1 and readyIn=1 for 10 words 4'h0..4'h9 -> count holds at 1 after the first edge. dataOut follows input one cycle late with all 10 in order across the pointer wrap.
- Full plus simultaneous read: at count=4, validIn=1 with 4'b0101 and readyIn=1 in the same cycle -> read happens, write is refused, count=3. 4'b0101 is accepted next cycle.
- Flush and async reset: with count=3, pulse flush alongside validIn=1 -> count=0, validOut=0, the word is dropped, and overflowErr is retained. Then write 2 words and assert reset between clock edges -> validOut=0 and count=0 immediately, before the next edge.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared constants and helpers for the data bus family of blocks.
package data_bus_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultDepth = 4;

  // Pointer width for a power-of-two buffer; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_bus_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module data_bus_mem #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word on the clock edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: combinational lookup of the addressed entry.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/data_bus_fifo.sv
// Valid/ready FIFO for the data bus. Status flags are decoded from the registered
// count only, so there is no combinational path from validIn/readyIn to the outputs.
module data_bus_fifo
  import data_bus_pkg::*;
#(
  parameter int unsigned  WIDTH = DefaultWidth,
  parameter int unsigned  DEPTH = DefaultDepth,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             validIn,
  output logic             readyOut,
  output logic [WIDTH-1:0] dataOut,
  output logic             validOut,
  input  logic             readyIn,
  output logic [CNT_W-1:0] count,
  output logic             overflowErr
);

  localparam int unsigned AW = ptr_width(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_en, rd_en, mem_we;
  logic [WIDTH-1:0] mem_rdata;

  data_bus_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (dataIn),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Output decode from registered state only.
  always_comb begin
    readyOut    = (count_q != CNT_W'(DEPTH));
    validOut    = (count_q != '0);
    dataOut     = validOut ? mem_rdata : '0;
    count       = count_q;
    overflowErr = overflow_q;
  end

  // Handshake qualification and next-state; flush beats any read or write.
  always_comb begin
    wr_en      = validIn && readyOut;
    rd_en      = validOut && readyIn;
    mem_we     = wr_en && !flush;
    overflow_d = overflow_q | (validIn && !readyOut);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // State registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Fill level stays within 0..DEPTH.
  assert property (@(posedge clk) disable iff (reset) count_q <= CNT_W'(DEPTH))
    else $error("data_bus_fifo: count exceeds DEPTH");

endmodule

// File: tb/tb_data_bus_fifo.sv
// Directed bench for data_bus_fifo with WIDTH=4, DEPTH=4.
module tb_data_bus_fifo;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [3:0] dataIn;
  logic       validIn;
  logic       readyOut;
  logic [3:0] dataOut;
  logic       validOut;
  logic       readyIn;
  logic [2:0] count;
  logic       overflowErr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  data_bus_fifo #(
    .WIDTH (4),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .dataIn      (dataIn),
    .validIn     (validIn),
    .readyOut    (readyOut),
    .dataOut     (dataOut),
    .validOut    (validOut),
    .readyIn     (readyIn),
    .count       (count),
    .overflowErr (overflowErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    validIn = 1'b1;
    dataIn  = d;
    step();
    validIn = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    dataIn  = '0;
    validIn = 1'b0;
    readyIn = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    step();

    // Reset then idle
    check_val("rst_count", 32'(count), 0);
    check_val("rst_valid", 32'(validOut), 0);
    check_val("rst_ready", 32'(readyOut), 1);
    check_val("rst_data", 32'(dataOut), 0);
    check_val("rst_ovf", 32'(overflowErr), 0);

    // Single word, one-cycle latency
    push(4'b0110);
    check_val("single_valid", 32'(validOut), 1);
    check_val("single_data", 32'(dataOut), 4'b0110);
    check_val("single_count", 32'(count), 1);
    readyIn = 1'b1;
    step();
    readyIn = 1'b0;
    check_val("single_drain_valid", 32'(validOut), 0);
    check_val("single_drain_count", 32'(count), 0);
    check_val("single_drain_data", 32'(dataOut), 0);

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) push(4'(i));
    check_val("fill_count", 32'(count), 4);
    check_val("fill_ready", 32'(readyOut), 0);
    check_val("fill_ovf_clear", 32'(overflowErr), 0);
    push(4'b1110);
    check_val("bp_count", 32'(count), 4);
    check_val("bp_ovf", 32'(overflowErr), 1);
    readyIn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_val("drain_valid", 32'(validOut), 1);
      check_val("drain_data", 32'(dataOut), 32'(i));
      step();
    end
    readyIn = 1'b0;
    check_val("drain_empty_valid", 32'(validOut), 0);
    check_val("drain_empty_data", 32'(dataOut), 0);

    // Streaming across the pointer wrap
    readyIn = 1'b1;
    validIn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataIn = 4'(i);
      step();
      check_val("stream_count", 32'(count), 1);
      check_val("stream_data", 32'(dataOut), 32'(i));
    end
    validIn = 1'b0;
    step();
    readyIn = 1'b0;
    check_val("stream_end_count", 32'(count), 0);

    // Full plus simultaneous read: write refused, read proceeds
    for (int i = 10; i <= 13; i++) push(4'(i));
    check_val("full2_count", 32'(count), 4);
    validIn = 1'b1;
    dataIn  = 4'b0101;
    readyIn = 1'b1;
    step();
    readyIn = 1'b0;
    check_val("fullrd_count", 32'(count), 3);
    check_val("fullrd_data", 32'(dataOut), 4'hB);
    step();
    validIn = 1'b0;
    check_val("fullrd_accept_count", 32'(count), 4);
    readyIn = 1'b1;
    check_val("order_b", 32'(dataOut), 4'hB);
    step();
    check_val("order_c", 32'(dataOut), 4'hC);
    step();
    check_val("order_d", 32'(dataOut), 4'hD);
    step();
    check_val("order_5", 32'(dataOut), 4'b0101);
    step();
    readyIn = 1'b0;
    check_val("order_empty", 32'(count), 0);

    // Flush beats a concurrent write and keeps overflowErr
    push(4'h7);
    push(4'h8);
    push(4'h9);
    check_val("preflush_count", 32'(count), 3);
    flush   = 1'b1;
    validIn = 1'b1;
    dataIn  = 4'hF;
    step();
    flush   = 1'b0;
    validIn = 1'b0;
    check_val("flush_count", 32'(count), 0);
    check_val("flush_valid", 32'(validOut), 0);
    check_val("flush_data", 32'(dataOut), 0);
    check_val("flush_ovf_kept", 32'(overflowErr), 1);
    push(4'h1);
    push(4'h2);
    check_val("postflush_count", 32'(count), 2);
    check_val("postflush_head", 32'(dataOut), 4'h1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check_val("async_valid", 32'(validOut), 0);
    check_val("async_count", 32'(count), 0);
    check_val("async_ovf", 32'(overflowErr), 0);
    check_val("async_data", 32'(dataOut), 0);
    #1;
    reset = 1'b0;
    step();
    check_val("post_rst_ready", 32'(readyOut), 1);
    check_val("post_rst_count", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
